// File: rtl/pic_cpu_if_pkg.sv
// Shared types and default timing for the CPU-side interrupt acknowledge initiator.
package pic_cpu_if_pkg;

   localparam int unsigned VECTOR_W             = 8;
   localparam int unsigned DEF_PULSE_WIDTH      = 4;
   localparam int unsigned DEF_GAP_WIDTH        = 2;
   localparam int unsigned DEF_RECOVER_CYCLES   = 3;
   localparam int unsigned DEF_SYNC_STAGES      = 2;

   // Binary-encoded acknowledge sequence states
   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StPulse1  = 3'd1,
      StGap     = 3'd2,
      StPulse2  = 3'd3,
      StHold    = 3'd4,
      StRecover = 3'd5
   } inta_state_e;

   // Largest of three timing constants; sizes the shared phase counter
   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/int_synchronizer.sv
// Multi-flop synchroniser bringing the asynchronous PIC INT level into the clk domain.
module int_synchronizer #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic sync_out
);

   logic [STAGES-1:0] chain;

   // Shift the raw level through the chain; the last stage is the usable value
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], async_in};
      end
   end

   assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/inta_cycle_initiator.sv
// Drives the two-pulse 8086-style INTA_n handshake, captures the vector byte on
// pulse 2 and presents it to the core over a valid/ack handshake.
module inta_cycle_initiator
   import pic_cpu_if_pkg::*;
#(
   parameter int unsigned PULSE_WIDTH    = DEF_PULSE_WIDTH,
   parameter int unsigned GAP_WIDTH      = DEF_GAP_WIDTH,
   parameter int unsigned RECOVER_CYCLES = DEF_RECOVER_CYCLES,
   parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                INT,
   input  logic                int_enable,
   input  logic [VECTOR_W-1:0] data_bus_in,
   input  logic                vector_ack,
   output logic                INTA_n,
   output logic [VECTOR_W-1:0] vector,
   output logic                vector_valid,
   output logic                busy
);

   localparam int unsigned CNT_W =
      $clog2(max3(PULSE_WIDTH, GAP_WIDTH, RECOVER_CYCLES) + 1);

   localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_WIDTH - 1);
   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_WIDTH - 1);
   localparam logic [CNT_W-1:0] RECOVER_LAST = CNT_W'(RECOVER_CYCLES - 1);

   inta_state_e      state;
   logic [CNT_W-1:0] count;
   logic             int_sync;

   int_synchronizer #(
      .STAGES (SYNC_STAGES)
   ) u_int_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (INT),
      .sync_out (int_sync)
   );

   // Sequence FSM; all outputs are registered and change only on the transition edge.
   // Once PULSE1 is entered the sequence runs to completion regardless of INT or int_enable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= StIdle;
         count        <= '0;
         INTA_n       <= 1'b1;
         vector       <= '0;
         vector_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (int_sync && int_enable) begin
                  state  <= StPulse1;
                  count  <= '0;
                  INTA_n <= 1'b0;
                  busy   <= 1'b1;
               end
            end
            StPulse1: begin
               if (count == PULSE_LAST) begin
                  state  <= StGap;
                  count  <= '0;
                  INTA_n <= 1'b1;
               end else begin
                  count <= count + CNT_W'(1);
               end
            end
            StGap: begin
               if (count == GAP_LAST) begin
                  state  <= StPulse2;
                  count  <= '0;
                  INTA_n <= 1'b0;
               end else begin
                  count <= count + CNT_W'(1);
               end
            end
            StPulse2: begin
               if (count == PULSE_LAST) begin
                  state        <= StHold;
                  count        <= '0;
                  INTA_n       <= 1'b1;
                  vector       <= data_bus_in;
                  vector_valid <= 1'b1;
               end else begin
                  count <= count + CNT_W'(1);
               end
            end
            StHold: begin
               if (vector_ack) begin
                  state        <= StRecover;
                  count        <= '0;
                  vector_valid <= 1'b0;
               end
            end
            StRecover: begin
               // Lets the PIC drop INT after the ack so a stale level cannot retrigger
               if (count == RECOVER_LAST) begin
                  state <= StIdle;
                  count <= '0;
                  busy  <= 1'b0;
               end else begin
                  count <= count + CNT_W'(1);
               end
            end
            default: begin
               state        <= StIdle;
               count        <= '0;
               INTA_n       <= 1'b1;
               vector_valid <= 1'b0;
               busy         <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inta_cycle_initiator.sv
// Self-checking bench for inta_cycle_initiator: table-driven sequences with a
// vector scoreboard, plus masked-start and mid-pulse reset sequences.
module tb_inta_cycle_initiator;

   localparam int PW = 4;
   localparam int GW = 2;
   localparam int RC = 3;
   localparam int SS = 2;

   logic       clk;
   logic       reset;
   logic       INT;
   logic       int_enable;
   logic [7:0] data_bus_in;
   logic       vector_ack;
   logic       INTA_n;
   logic [7:0] vector;
   logic       vector_valid;
   logic       busy;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] exp_q[$];

   typedef struct {
      logic [7:0] bus;
      logic [7:0] exp_vec;
      bit         drop_int;
      bit         early_ack;
      int         ack_wait;
      bit         check_rec;
      int         exp_wait;
   } vec_t;

   vec_t tbl[5];

   inta_cycle_initiator dut (
      .clk          (clk),
      .reset        (reset),
      .INT          (INT),
      .int_enable   (int_enable),
      .data_bus_in  (data_bus_in),
      .vector_ack   (vector_ack),
      .INTA_n       (INTA_n),
      .vector       (vector),
      .vector_valid (vector_valid),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Advance negedges until INTA_n is low; returns cycles waited (bounded)
   task automatic wait_low(output int cyc);
      cyc = 0;
      while (INTA_n !== 1'b0 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   // Entered at the first negedge of pulse 1; runs the rest of the sequence and handshake
   task automatic do_seq(input logic [7:0] bus, input logic [7:0] exp_vec, input bit drop_int,
                         input bit early_ack, input int ack_wait, input bit check_rec);
      int  cnt;
      bit  ok;
      logic [7:0] e;
      chk("busy_pulse1", busy, 1);
      cnt = 0;
      while (INTA_n === 1'b0 && cnt < 64) begin
         cnt++;
         @(negedge clk);
      end
      chk("pulse1_len", cnt, PW);
      if (drop_int) INT = 1'b0;
      if (early_ack) vector_ack = 1'b1;
      data_bus_in = 8'hEE;
      cnt = 0;
      while (INTA_n === 1'b1 && cnt < 64) begin
         chk("busy_gap", busy, 1);
         cnt++;
         @(negedge clk);
      end
      chk("gap_len", cnt, GW);
      vector_ack  = 1'b0;
      data_bus_in = bus;
      exp_q.push_back(exp_vec);
      cnt = 0;
      while (INTA_n === 1'b0 && cnt < 64) begin
         cnt++;
         @(negedge clk);
      end
      chk("pulse2_len", cnt, PW);
      data_bus_in = ~bus;
      chk("valid_set", vector_valid, 1);
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 1, 0);
         e = 8'hxx;
      end else begin
         e = exp_q.pop_front();
      end
      chk("vector_capture", vector, e);
      ok = 1'b1;
      for (int i = 0; i < ack_wait; i++) begin
         @(negedge clk);
         if (vector_valid !== 1'b1 || INTA_n !== 1'b1 || busy !== 1'b1 || vector !== e)
            ok = 1'b0;
      end
      chk("hold_stable", ok, 1);
      vector_ack = 1'b1;
      @(negedge clk);
      vector_ack = 1'b0;
      chk("valid_clear", vector_valid, 0);
      chk("vector_kept", vector, e);
      chk("busy_recover", busy, 1);
      if (check_rec) begin
         cnt = 0;
         while (INTA_n !== 1'b0 && cnt < 64) begin
            @(negedge clk);
            cnt++;
         end
         chk("recover_to_pulse1", cnt, RC + 1);
      end else if (drop_int) begin
         ok = 1'b1;
         for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (INTA_n !== 1'b1) ok = 1'b0;
         end
         chk("no_retrigger", ok, 1);
         chk("idle_busy", busy, 0);
      end
   endtask

   initial begin
      int  cyc;
      int  cnt;
      bit  ok;

      tbl[0] = '{bus: 8'h4A, exp_vec: 8'h4A, drop_int: 0, early_ack: 0, ack_wait: 2,
                 check_rec: 1, exp_wait: 1};
      tbl[1] = '{bus: 8'h0F, exp_vec: 8'h0F, drop_int: 1, early_ack: 0, ack_wait: 1,
                 check_rec: 0, exp_wait: 0};
      tbl[2] = '{bus: 8'hA5, exp_vec: 8'hA5, drop_int: 0, early_ack: 0, ack_wait: 20,
                 check_rec: 1, exp_wait: SS + 1};
      tbl[3] = '{bus: 8'h20, exp_vec: 8'h20, drop_int: 0, early_ack: 1, ack_wait: 0,
                 check_rec: 1, exp_wait: 0};
      tbl[4] = '{bus: 8'h21, exp_vec: 8'h21, drop_int: 1, early_ack: 0, ack_wait: 0,
                 check_rec: 0, exp_wait: 0};

      reset       = 1'b0;
      INT         = 1'b0;
      int_enable  = 1'b0;
      data_bus_in = 8'h00;
      vector_ack  = 1'b0;
      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_inta_n", INTA_n, 1);
      chk("reset_vector", vector, 8'h00);
      chk("reset_valid", vector_valid, 0);
      chk("reset_busy", busy, 0);
      reset = 1'b0;

      // Masked: INT high but interrupts disabled
      INT = 1'b1;
      ok  = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (INTA_n !== 1'b1 || busy !== 1'b0) ok = 1'b0;
      end
      chk("masked_idle", ok, 1);

      // Table sequences; record 0 raises int_enable after the masked window
      for (int r = 0; r < 5; r++) begin
         INT        = 1'b1;
         int_enable = 1'b1;
         wait_low(cyc);
         chk($sformatf("start_wait[%0d]", r), cyc, tbl[r].exp_wait);
         do_seq(tbl[r].bus, tbl[r].exp_vec, tbl[r].drop_int, tbl[r].early_ack,
                tbl[r].ack_wait, tbl[r].check_rec);
      end

      // Reset in cycle 2 of pulse 2
      INT = 1'b1;
      wait_low(cyc);
      chk("rst_seq_start", cyc, SS + 1);
      cnt = 0;
      while (INTA_n === 1'b0 && cnt < 64) begin
         cnt++;
         @(negedge clk);
      end
      cnt = 0;
      while (INTA_n === 1'b1 && cnt < 64) begin
         cnt++;
         @(negedge clk);
      end
      data_bus_in = 8'h77;
      @(negedge clk);
      chk("rst_pre_inta_low", INTA_n, 0);
      reset = 1'b1;
      #1;
      chk("rst_async_inta_n", INTA_n, 1);
      chk("rst_async_valid", vector_valid, 0);
      chk("rst_async_busy", busy, 0);
      chk("rst_async_vector", vector, 8'h00);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      wait_low(cyc);
      chk("post_rst_start", cyc, SS + 1);
      do_seq(8'h5C, 8'h5C, 1'b1, 1'b0, 3, 1'b0);

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
